// File: rtl/input_mode_sequencer.sv
// Front-panel input-type selector: sample tick, button sync/debounce, mode stepping and lock.
// Optional build macro AUTO_SCROLL_EN enables hold-to-scroll in the HOLD state.
module input_mode_sequencer #(
  parameter logic [23:0] TICK_DIV       = 24'd524288,
  parameter int          NUM_MODES      = 4,
  parameter int          DEBOUNCE_TICKS = 2,
  parameter int          HOLD_TICKS     = 8
) (
  input  logic       clk_10MHz,
  input  logic       reset,
  input  logic       next_n,
  input  logic       confirm_n,
  output logic [1:0] sel,
  output logic       locked,
  output logic       sel_changed,
  output logic       tick
);

  localparam int             DW       = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DW-1:0]  DB_LAST  = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [1:0]     SEL_LAST = 2'(NUM_MODES - 1);
  localparam int             BN       = 0;
  localparam int             BC       = 1;

  typedef enum logic [1:0] {
    SELECT = 2'd0,
    HOLD   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  if ((TICK_DIV < 24'd2) || (NUM_MODES < 2) || (NUM_MODES > 4) ||
      (DEBOUNCE_TICKS < 1) || (HOLD_TICKS < 1)) begin : g_param_check
    $error("input_mode_sequencer: illegal parameter value");
  end

  logic [23:0]   count_r;
  logic          tick_d_r;
  logic [1:0]    sync1_r;
  logic [1:0]    sync2_r;
  logic [1:0]    pressed_s;
  logic [1:0]    level_r;
  logic [1:0]    level_prev_r;
  logic [DW-1:0] run_r [2];
  logic          next_armed_r;
  logic          next_press_s;
  logic          next_release_s;
  logic          confirm_press_s;
  state_t        state_r;

  function automatic logic [1:0] step_sel(input logic [1:0] cur);
    if (cur >= SEL_LAST) begin
      step_sel = 2'd0;
    end else begin
      step_sel = cur + 2'd1;
    end
  endfunction

  // Free-running sample tick; tick_d_r lines up with the debounced edge pulses.
  always_ff @(posedge clk_10MHz or posedge reset) begin
    if (reset) begin
      count_r  <= 24'd0;
      tick     <= 1'b0;
      tick_d_r <= 1'b0;
    end else begin
      if (count_r == TICK_DIV - 24'd1) begin
        count_r <= 24'd0;
      end else begin
        count_r <= count_r + 24'd1;
      end
      tick     <= (count_r == TICK_DIV - 24'd2);
      tick_d_r <= tick;
    end
  end

  assign pressed_s = ~sync2_r;

  // Synchronize and debounce both buttons; NEXT is armed only after a released sample.
  always_ff @(posedge clk_10MHz or posedge reset) begin
    if (reset) begin
      sync1_r      <= 2'b11;
      sync2_r      <= 2'b11;
      level_r      <= 2'b00;
      level_prev_r <= 2'b00;
      run_r[0]     <= '0;
      run_r[1]     <= '0;
      next_armed_r <= 1'b0;
    end else begin
      sync1_r      <= {confirm_n, next_n};
      sync2_r      <= sync1_r;
      level_prev_r <= level_r;
      if (tick) begin
        for (int i = 0; i < 2; i++) begin
          if (pressed_s[i] != level_r[i]) begin
            if (run_r[i] == DB_LAST) begin
              level_r[i] <= pressed_s[i];
              run_r[i]   <= '0;
            end else begin
              run_r[i] <= run_r[i] + DW'(1);
            end
          end else begin
            run_r[i] <= '0;
          end
        end
        if (!pressed_s[BN]) begin
          next_armed_r <= 1'b1;
        end
      end
    end
  end

  assign next_press_s    = level_r[BN] & ~level_prev_r[BN] & next_armed_r;
  assign next_release_s  = ~level_r[BN] & level_prev_r[BN];
  assign confirm_press_s = level_r[BC] & ~level_prev_r[BC];

`ifdef AUTO_SCROLL_EN
  localparam int            HW        = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  logic [HW-1:0] hold_cnt_r;
`endif

  // Mode FSM; confirm outranks next, and a held NEXT never re-triggers without release.
  always_ff @(posedge clk_10MHz or posedge reset) begin
    if (reset) begin
      state_r     <= SELECT;
      sel         <= 2'd0;
      locked      <= 1'b0;
      sel_changed <= 1'b0;
`ifdef AUTO_SCROLL_EN
      hold_cnt_r  <= '0;
`endif
    end else begin
      sel_changed <= 1'b0;
      case (state_r)
        SELECT: begin
          if (confirm_press_s) begin
            locked  <= 1'b1;
            state_r <= LOCKED;
          end else if (next_press_s) begin
            sel         <= step_sel(sel);
            sel_changed <= 1'b1;
            state_r     <= HOLD;
`ifdef AUTO_SCROLL_EN
            hold_cnt_r  <= '0;
`endif
          end
        end
        HOLD: begin
          if (confirm_press_s) begin
            locked  <= 1'b1;
            state_r <= LOCKED;
          end else if (next_release_s) begin
            state_r <= SELECT;
`ifdef AUTO_SCROLL_EN
          end else if (tick_d_r) begin
            if (hold_cnt_r == HOLD_LAST) begin
              sel         <= step_sel(sel);
              sel_changed <= 1'b1;
              hold_cnt_r  <= '0;
            end else begin
              hold_cnt_r <= hold_cnt_r + HW'(1);
            end
`endif
          end
        end
        LOCKED: begin
          if (confirm_press_s) begin
            locked  <= 1'b0;
            state_r <= SELECT;
          end
        end
        default: begin
          state_r <= SELECT;
          locked  <= 1'b0;
        end
      endcase
    end
  end

endmodule
